// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between the EX/ME and ME/WB registers.
// Issues loads/stores on a valid/ready port and aligns load data for write-back.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        me_mem_rena,
  input  logic        me_mem_wena,
  input  logic        me_mem_ext_un,
  input  logic        me_mem_to_reg,
  input  logic [7:0]  me_mem_byte_enable,
  input  logic [63:0] me_alu_result,
  input  logic [63:0] me_new_rs2_data,
  input  logic        me_rd_wena,
  input  logic [4:0]  me_rd_waddr,
  input  logic [63:0] me_pc,
  input  logic [31:0] me_inst,
  input  logic        me_advance,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_resp_valid,
  input  logic [63:0] dmem_rdata,
  output logic        mem_stall_req,
  output logic        mem_rd_wena,
  output logic [4:0]  mem_rd_waddr,
  output logic [63:0] mem_rd_wdata,
  output logic [63:0] mem_pc,
  output logic [31:0] mem_inst
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [63:0] rdata_q;
  logic        access;
  logic        cap;
  logic [5:0]  sh;
  logic [3:0]  nbytes;
  logic        sz_b;
  logic        sz_h;
  logic        sz_w;
  logic        sgn;
  logic [63:0] shifted;
  logic [63:0] load_val;

  // A zero byte mask turns the instruction into a plain ALU op.
  assign access = (me_mem_rena | me_mem_wena) & (|me_mem_byte_enable);
  assign sh     = {me_alu_result[2:0], 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (cap) begin
      rdata_q <= dmem_rdata;
    end
  end

  always_comb begin
    state_d        = state_q;
    dmem_req_valid = 1'b0;
    cap            = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          dmem_req_valid = 1'b1;
          if (dmem_req_ready) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_resp_valid) begin
          cap     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (me_advance) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem_we    = me_mem_wena & access;
  assign dmem_addr  = {me_alu_result[63:3], 3'b000};
  assign dmem_wdata = me_new_rs2_data << sh;
  assign dmem_wstrb = me_mem_byte_enable;

  always_comb begin
    nbytes = '0;
    for (int i = 0; i < 8; i++) begin
      nbytes = nbytes + {3'b000, me_mem_byte_enable[i]};
    end
  end

  assign sz_b    = (nbytes == 4'd1);
  assign sz_h    = (nbytes == 4'd2);
  assign sz_w    = (nbytes == 4'd4);
  assign shifted = rdata_q >> sh;

  always_comb begin
    sgn      = 1'b0;
    load_val = shifted;
    unique case (1'b1)
      sz_b: begin
        sgn      = ~me_mem_ext_un & shifted[7];
        load_val = {{56{sgn}}, shifted[7:0]};
      end
      sz_h: begin
        sgn      = ~me_mem_ext_un & shifted[15];
        load_val = {{48{sgn}}, shifted[15:0]};
      end
      sz_w: begin
        sgn      = ~me_mem_ext_un & shifted[31];
        load_val = {{32{sgn}}, shifted[31:0]};
      end
      default: load_val = shifted;
    endcase
  end

  assign mem_stall_req = access & (state_q != DONE);
  assign mem_rd_wena   = me_rd_wena & ~mem_stall_req;
  assign mem_rd_waddr  = me_rd_waddr;
  assign mem_rd_wdata  = (me_mem_to_reg & access) ? load_val : me_alu_result;
  assign mem_pc        = me_pc;
  assign mem_inst      = me_inst;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: load vector table, directed corner sequences and
// randomized loads/stores/ALU ops against a byte-level memory model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        me_mem_rena, me_mem_wena, me_mem_ext_un, me_mem_to_reg;
  logic [7:0]  me_mem_byte_enable;
  logic [63:0] me_alu_result, me_new_rs2_data, me_pc;
  logic        me_rd_wena, me_advance;
  logic [4:0]  me_rd_waddr;
  logic [31:0] me_inst;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_resp_valid;
  logic        mem_stall_req, mem_rd_wena;
  logic [4:0]  mem_rd_waddr;
  logic [63:0] mem_rd_wdata, mem_pc;
  logic [31:0] mem_inst;
  logic        any_out;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .me_mem_rena(me_mem_rena), .me_mem_wena(me_mem_wena),
    .me_mem_ext_un(me_mem_ext_un), .me_mem_to_reg(me_mem_to_reg),
    .me_mem_byte_enable(me_mem_byte_enable),
    .me_alu_result(me_alu_result), .me_new_rs2_data(me_new_rs2_data),
    .me_rd_wena(me_rd_wena), .me_rd_waddr(me_rd_waddr),
    .me_pc(me_pc), .me_inst(me_inst), .me_advance(me_advance),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
    .mem_stall_req(mem_stall_req), .mem_rd_wena(mem_rd_wena),
    .mem_rd_waddr(mem_rd_waddr), .mem_rd_wdata(mem_rd_wdata),
    .mem_pc(mem_pc), .mem_inst(mem_inst)
  );

  assign any_out = |{dmem_req_valid, dmem_we, dmem_addr, dmem_wdata,
                     dmem_wstrb, mem_stall_req, mem_rd_wena, mem_rd_waddr,
                     mem_rd_wdata, mem_pc, mem_inst};

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [0:63];

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  be;
    logic        un;
    logic [63:0] rdata;
    logic [63:0] exp;
  } ld_vec_t;
  ld_vec_t lv [8];

  logic [63:0] wd, a_addr, a_wdata;
  logic [7:0]  a_strb;
  logic        a_we;
  int          sn, rn, bd;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_me();
    me_mem_rena = 0; me_mem_wena = 0; me_mem_ext_un = 0;
    me_mem_to_reg = 0; me_mem_byte_enable = '0;
    me_alu_result = '0; me_new_rs2_data = '0; me_pc = '0;
    me_rd_wena = 0; me_rd_waddr = '0; me_inst = '0;
  endtask

  task automatic set_op(input logic rena, wena, un, to_reg,
                        input logic [7:0] be,
                        input logic [63:0] addr, rs2);
    me_mem_rena = rena; me_mem_wena = wena; me_mem_ext_un = un;
    me_mem_to_reg = to_reg; me_mem_byte_enable = be;
    me_alu_result = addr; me_new_rs2_data = rs2;
    me_rd_wena = ~wena;
    me_rd_waddr = 5'($urandom_range(1, 31));
    me_pc = addr ^ 64'h1000;
    me_inst = $urandom;
  endtask

  // Memory-side model of one access: accept after rdy_dly cycles,
  // respond rsp_dly cycles after acceptance, advance adv_dly after that.
  task automatic run_op(input int rdy_dly, rsp_dly, adv_dly,
                        input logic [63:0] rsp);
    int ph, cnt;
    logic first;
    ph = 0; cnt = 0; first = 1;
    sn = 0; rn = 0; bd = 0; wd = '0;
    a_addr = '0; a_wdata = '0; a_strb = '0; a_we = 0;
    for (int cyc = 0; cyc < 200 && ph < 3; cyc++) begin
      dmem_req_ready  = (ph == 0) && (cnt >= rdy_dly);
      dmem_resp_valid = (ph == 1) ? (cnt >= rsp_dly)
                      : (ph == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      dmem_rdata = (ph == 1 && dmem_resp_valid) ? rsp
                                                : {$urandom, $urandom};
      me_advance = (ph == 2) && (cnt >= adv_dly);
      @(negedge clk);
      if (mem_stall_req) sn++;
      if (dmem_req_valid) begin
        rn++;
        if (first) begin
          a_addr = dmem_addr; a_wdata = dmem_wdata;
          a_strb = dmem_wstrb; a_we = dmem_we; first = 0;
        end else if ({a_addr, a_wdata, a_strb, a_we} !==
                     {dmem_addr, dmem_wdata, dmem_wstrb, dmem_we}) begin
          bd++;
        end
      end
      if (ph == 0 && dmem_req_ready && !dmem_req_valid) bd++;
      if (mem_stall_req && mem_rd_wena) bd++;
      if (ph == 2) begin
        if (cnt == 0) wd = mem_rd_wdata;
        else if (mem_rd_wdata !== wd) bd++;
        if (mem_stall_req || mem_rd_wena !== me_rd_wena) bd++;
      end
      @(posedge clk); #1;
      if ((ph == 0 && dmem_req_ready) || (ph == 1 && dmem_resp_valid) ||
          (ph == 2 && me_advance)) begin
        ph++; cnt = 0;
      end else begin
        cnt++;
      end
    end
    if (ph < 3) bd += 1000;
    dmem_req_ready = 0; dmem_resp_valid = 0; me_advance = 0;
  endtask

  function automatic logic [63:0] mem_dw(input logic [63:0] addr);
    logic [63:0] v;
    for (int i = 0; i < 8; i++)
      v[8*i +: 8] = ref_mem[int'({addr[5:3], 3'b000}) + i];
    return v;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] addr,
                                           input int size,
                                           input logic un);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < size; i++)
      v[8*i +: 8] = ref_mem[int'(addr[5:0]) + i];
    if (!un && v[8*size-1])
      for (int i = size; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  initial begin
    logic [63:0] addr, rs2, alu, exp;
    logic [15:0] m;
    logic [7:0]  be;
    int size, off, kind, d0, d1, d2;

    rst = 1;
    clear_me();
    dmem_req_ready = 0; dmem_resp_valid = 0;
    dmem_rdata = '0; me_advance = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom);

    lv[0] = '{64'h8000_0003, 8'h08, 1'b0, 64'h0000_0000_8500_0000,
              64'hFFFF_FFFF_FFFF_FF85};
    lv[1] = '{64'h8000_0004, 8'hF0, 1'b1, 64'hDEAD_BEEF_0000_0000,
              64'h0000_0000_DEAD_BEEF};
    lv[2] = '{64'h8000_0004, 8'hF0, 1'b0, 64'hDEAD_BEEF_0000_0000,
              64'hFFFF_FFFF_DEAD_BEEF};
    lv[3] = '{64'h8000_0006, 8'hC0, 1'b0, 64'h7FFF_0000_0000_0000,
              64'h0000_0000_0000_7FFF};
    lv[4] = '{64'h8000_0002, 8'h0C, 1'b1, 64'h0000_0000_ABCD_0000,
              64'h0000_0000_0000_ABCD};
    lv[5] = '{64'h8000_0008, 8'hFF, 1'b0, 64'h0123_4567_89AB_CDEF,
              64'h0123_4567_89AB_CDEF};
    lv[6] = '{64'h8000_0007, 8'h80, 1'b1, 64'hF000_0000_0000_0000,
              64'h0000_0000_0000_00F0};
    lv[7] = '{64'h8000_0000, 8'h01, 1'b0, 64'h0000_0000_0000_007F,
              64'h0000_0000_0000_007F};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'(any_out), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("post_reset_outputs", 64'(any_out), 64'd0);
    @(posedge clk); #1;

    foreach (lv[k]) begin
      set_op(1, 0, lv[k].un, 1, lv[k].be, lv[k].addr, '0);
      run_op(0, 0, 0, lv[k].rdata);
      chk($sformatf("vec%0d_data", k), wd, lv[k].exp);
      chk($sformatf("vec%0d_addr", k), a_addr,
          lv[k].addr & ~64'h7);
      chk($sformatf("vec%0d_stall", k), 64'(sn), 64'd2);
      chk($sformatf("vec%0d_proto", k), 64'(bd), 64'd0);
    end

    set_op(0, 1, 0, 0, 8'h0C, 64'h8000_0002, 64'h1234_5678_9ABC_1122);
    run_op(3, 0, 0, '0);
    chk("sh_req_cycles", 64'(rn), 64'd4);
    chk("sh_wdata", a_wdata, 64'h5678_9ABC_1122_0000);
    chk("sh_wstrb", 64'(a_strb), 64'h0C);
    chk("sh_we", 64'(a_we), 64'd1);
    chk("sh_proto", 64'(bd), 64'd0);

    set_op(1, 0, 0, 1, 8'hFF, 64'h8000_0010, '0);
    run_op(0, 1, 5, 64'hCAFE_F00D_1234_5678);
    chk("hold_req_cycles", 64'(rn), 64'd1);
    chk("hold_stall", 64'(sn), 64'd3);
    chk("hold_data", wd, 64'hCAFE_F00D_1234_5678);
    chk("hold_proto", 64'(bd), 64'd0);

    set_op(1, 0, 0, 1, 8'hFF, 64'h8000_0018, '0);
    dmem_req_ready = 1;
    @(negedge clk);
    chk("rst_seq_req", 64'(dmem_req_valid), 64'd1);
    @(posedge clk); #1;
    dmem_req_ready = 0;
    #2;
    rst = 1;
    clear_me();
    #1;
    chk("rst_in_wait_outputs", 64'(any_out), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    dmem_resp_valid = 1;
    dmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    chk("late_resp_outputs", 64'(any_out), 64'd0);
    @(posedge clk); #1;
    dmem_resp_valid = 0;
    set_op(1, 0, 0, 1, 8'hFF, 64'h8000_0020, '0);
    @(negedge clk);
    chk("after_rst_idle_req", 64'(dmem_req_valid), 64'd1);
    chk("after_rst_stall", 64'(mem_stall_req), 64'd1);
    @(posedge clk); #1;
    run_op(0, 0, 0, mem_dw(64'h8000_0020));
    chk("after_rst_load", wd, ref_load(64'h8000_0020, 8, 0));

    set_op(0, 0, 0, 0, 8'h00, 64'h42, '0);
    me_rd_wena = 1; me_rd_waddr = 5'd5;
    @(negedge clk);
    chk("add_wdata", mem_rd_wdata, 64'h42);
    chk("add_waddr", 64'(mem_rd_waddr), 64'd5);
    chk("add_wena", 64'(mem_rd_wena), 64'd1);
    chk("add_stall", 64'(mem_stall_req), 64'd0);
    @(posedge clk); #1;
    set_op(1, 0, 0, 1, 8'h00, 64'h8000_0033, '0);
    @(negedge clk);
    chk("nobe_wdata", mem_rd_wdata, 64'h8000_0033);
    chk("nobe_req", 64'(dmem_req_valid), 64'd0);
    chk("nobe_stall", 64'(mem_stall_req), 64'd0);
    @(posedge clk); #1;

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      size = 1 << $urandom_range(0, 3);
      off  = $urandom_range(0, 8 / size - 1) * size;
      addr = 64'h8000_0000 + 64'($urandom_range(0, 7) * 8 + off);
      m    = (16'd1 << size) - 16'd1;
      be   = m[7:0] << off;
      d0 = $urandom_range(0, 2);
      d1 = $urandom_range(0, 2);
      d2 = $urandom_range(0, 2);
      if (kind == 0) begin
        set_op(1, 0, 1'($urandom_range(0, 1)), 1, be, addr, '0);
        exp = ref_load(addr, size, me_mem_ext_un);
        run_op(d0, d1, d2, mem_dw(addr));
        chk($sformatf("rnd%0d_load", n), wd, exp);
      end else if (kind == 1) begin
        rs2 = {$urandom, $urandom};
        set_op(0, 1, 0, 0, be, addr, rs2);
        run_op(d0, d1, d2, '0);
        chk($sformatf("rnd%0d_wdata", n), a_wdata, rs2 << (8 * off));
        chk($sformatf("rnd%0d_wstrb", n), 64'(a_strb), 64'(be));
        for (int i = 0; i < size; i++)
          ref_mem[int'(addr[5:0]) + i] = rs2[8*i +: 8];
      end else begin
        alu = {$urandom, $urandom};
        set_op(0, 0, 0, 0, 8'h00, alu, '0);
        me_advance = 1;
        @(negedge clk);
        chk($sformatf("rnd%0d_alu", n), mem_rd_wdata, alu);
        sn = mem_stall_req ? 1 : 0;
        bd = (dmem_req_valid || !mem_rd_wena) ? 1 : 0;
        @(posedge clk); #1;
        me_advance = 0;
        d0 = -1; d1 = -1;
      end
      chk($sformatf("rnd%0d_stall", n), 64'(sn), 64'(d0 + d1 + 2));
      chk($sformatf("rnd%0d_proto", n), 64'(bd), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
